kv_stream_scheduler: RTL

- Sequences K and V vector streaming for one Q tile.
- Walks key index 0..seq_len-1 and issues reads to KSRAM/VSRAM (1-cycle read latency).
- Registers each returned vector and broadcasts it to all NUM_PES processing elements with a barrier handshake: a transfer completes only when every PE is ready.
- Sits between the K/V SRAMs and the PE array; started by the top-level control once per Q tile.

---
 rtl/kv_stream_scheduler_pkg.sv | 24 ++
 rtl/kv_stream_scheduler_bcast_channel.sv | 137 +++++++++++++
 rtl/kv_stream_scheduler.sv | 110 +++++++++++
 3 files changed

// File: rtl/kv_stream_scheduler_pkg.sv
// kv_stream_scheduler_pkg
// Shared sizing, vector types and state encodings for the K/V stream
// scheduler and its broadcast channels.
package kv_stream_scheduler_pkg;

  localparam int NUM_PES = 4;
  localparam int MAX_SEQ = 64;
  localparam int ADDR_W  = $clog2(MAX_SEQ);
  localparam int VEC_W   = 512;
  localparam int CNT_W   = ADDR_W + 1;

  typedef logic [VEC_W-1:0] K_VECTOR_T;
  typedef logic [VEC_W-1:0] V_VECTOR_T;

  typedef enum logic [1:0] {TOP_IDLE, TOP_RUN, TOP_DONE} top_state_t;
  typedef enum logic [1:0] {CH_EMPTY, CH_FETCH, CH_HOLD} ch_state_t;

  // A tile can never be longer than the SRAM depth; clamping keeps every
  // issued address inside the array even for an out-of-range request.
  function automatic logic [CNT_W-1:0] clamp_len(input logic [CNT_W-1:0] n);
    return (n > CNT_W'(MAX_SEQ)) ? CNT_W'(MAX_SEQ) : n;
  endfunction

endpackage

// File: rtl/kv_stream_scheduler_bcast_channel.sv
// kv_bcast_channel
// One broadcast channel: issues SRAM reads for indices 0..len-1, registers
// the returned vector and holds it until every PE is ready (barrier).
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   i_run        tile in progress; reads are only issued while high
//   i_clr        clears counters at the start of a new tile
//   i_len        number of vectors in the tile
//   i_gate       an index may issue only while it is below this limit
//   i_rdata      SRAM data, valid the cycle after o_re
//   i_rdy        per-PE ready
//   o_re/o_raddr SRAM read enable and address
//   o_vld/o_vector broadcast valid and vector
//   o_acc        number of completed transfers
// Build option: KV_PREFETCH_EN adds a one-entry prefetch buffer so the
// channel can sustain one transfer per cycle.
//
// state    | meaning
// CH_EMPTY | output register free, read issued when allowed
// CH_FETCH | read in flight, data captured at end of cycle
// CH_HOLD  | vector valid, waiting for all PEs ready
module kv_bcast_channel
  import kv_stream_scheduler_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_run,
  input  logic               i_clr,
  input  logic [CNT_W-1:0]   i_len,
  input  logic [CNT_W-1:0]   i_gate,
  input  logic [VEC_W-1:0]   i_rdata,
  input  logic [NUM_PES-1:0] i_rdy,
  output logic               o_re,
  output logic [ADDR_W-1:0]  o_raddr,
  output logic               o_vld,
  output logic [VEC_W-1:0]   o_vector,
  output logic [CNT_W-1:0]   o_acc
);

  logic [CNT_W-1:0] r_issue;
  logic [CNT_W-1:0] r_acc;
  logic [VEC_W-1:0] r_vec;
  logic             r_vld;
  logic             w_avail;
  logic             w_xfer;

  assign w_avail  = i_run && (r_issue < i_len) && (r_issue < i_gate);
  assign w_xfer   = r_vld && (&i_rdy);
  assign o_raddr  = r_issue[ADDR_W-1:0];
  assign o_vld    = r_vld;
  assign o_vector = r_vec;
  assign o_acc    = r_acc;

`ifdef KV_PREFETCH_EN
  logic             r_pend;
  logic             r_bvld;
  logic [VEC_W-1:0] r_buf;
  logic [1:0]       w_occ;

  // Output register plus buffer give two slots; a read in flight already
  // owns one. Issue only if a slot is still free after this cycle's transfer.
  assign w_occ = {1'b0, r_vld} + {1'b0, r_bvld} + {1'b0, r_pend};
  assign o_re  = w_avail && ((w_occ - {1'b0, w_xfer}) < 2'd2);

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_issue <= '0;
      r_acc   <= '0;
      r_vec   <= '0;
      r_vld   <= 1'b0;
      r_pend  <= 1'b0;
      r_bvld  <= 1'b0;
      r_buf   <= '0;
    end else begin
      r_pend <= o_re;
      if (o_re)   r_issue <= r_issue + CNT_W'(1);
      if (w_xfer) r_acc   <= r_acc + CNT_W'(1);
      if (!r_vld || w_xfer) begin
        // Oldest data first: buffer, then the SRAM word arriving now.
        if (r_bvld) begin
          r_vec  <= r_buf;
          r_vld  <= 1'b1;
          r_bvld <= r_pend;
          if (r_pend) r_buf <= i_rdata;
        end else if (r_pend) begin
          r_vec <= i_rdata;
          r_vld <= 1'b1;
        end else begin
          r_vld <= 1'b0;
        end
      end else if (r_pend) begin
        r_buf  <= i_rdata;
        r_bvld <= 1'b1;
      end
    end
  end
`else
  ch_state_t r_state;
  ch_state_t w_next;

  always_comb begin
    w_next = r_state;
    o_re   = 1'b0;
    case (r_state)
      CH_EMPTY: if (w_avail) begin
        o_re   = 1'b1;
        w_next = CH_FETCH;
      end
      CH_FETCH: w_next = CH_HOLD;
      CH_HOLD:  if (w_xfer) w_next = CH_EMPTY;
      default:  w_next = CH_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_state <= CH_EMPTY;
      r_issue <= '0;
      r_acc   <= '0;
      r_vec   <= '0;
      r_vld   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (o_re) r_issue <= r_issue + CNT_W'(1);
      if (r_state == CH_FETCH) begin
        r_vec <= i_rdata;
        r_vld <= 1'b1;
      end
      if (w_xfer) begin
        r_vld <= 1'b0;
        r_acc <= r_acc + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: rtl/kv_stream_scheduler.sv
// kv_stream_scheduler
// Streams K and V vectors for one Q tile from KSRAM/VSRAM to the PE array.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, seq_len      begin a tile of seq_len keys (ignored while busy)
//   busy, done          tile in progress / one-cycle completion pulse
//   k_re/k_raddr/k_rdata  KSRAM read port (1-cycle latency)
//   v_re/v_raddr/v_rdata  VSRAM read port (1-cycle latency)
//   K_vld/K_rdy/k_vector  K broadcast, completes when all PEs ready
//   V_vld/V_rdy/v_vector  V broadcast, completes when all PEs ready
// Build option: KV_PREFETCH_EN enables per-channel prefetch buffers.
//
// state    | meaning
// TOP_IDLE | waiting for start
// TOP_RUN  | channels streaming the tile
// TOP_DONE | one-cycle done pulse
module kv_stream_scheduler
  import kv_stream_scheduler_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_W:0]    seq_len,
  output logic               busy,
  output logic               done,
  output logic               k_re,
  output logic [ADDR_W-1:0]  k_raddr,
  input  logic [VEC_W-1:0]   k_rdata,
  output logic               v_re,
  output logic [ADDR_W-1:0]  v_raddr,
  input  logic [VEC_W-1:0]   v_rdata,
  output logic               K_vld,
  input  logic [NUM_PES-1:0] K_rdy,
  output logic [VEC_W-1:0]   k_vector,
  output logic               V_vld,
  input  logic [NUM_PES-1:0] V_rdy,
  output logic [VEC_W-1:0]   v_vector
);

  top_state_t       r_state;
  top_state_t       w_next;
  logic [CNT_W-1:0] r_len;
  logic [CNT_W-1:0] w_k_acc;
  logic [CNT_W-1:0] w_v_acc;
  logic             w_accept;
  logic             w_run;
  K_VECTOR_T        w_k_vec;
  V_VECTOR_T        w_v_vec;

  assign w_accept = start && (r_state == TOP_IDLE);
  assign w_run    = (r_state == TOP_RUN);
  assign busy     = w_run;
  assign done     = (r_state == TOP_DONE);
  assign k_vector = w_k_vec;
  assign v_vector = w_v_vec;

  always_comb begin
    w_next = r_state;
    case (r_state)
      TOP_IDLE: if (start) w_next = (seq_len == '0) ? TOP_DONE : TOP_RUN;
      TOP_RUN:  if ((w_k_acc == r_len) && (w_v_acc == r_len)) w_next = TOP_DONE;
      TOP_DONE: w_next = TOP_IDLE;
      default:  w_next = TOP_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= TOP_IDLE;
      r_len   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) r_len <= clamp_len(seq_len);
    end
  end

  kv_bcast_channel u_k_chan (
    .clk      (clk),
    .rst      (rst),
    .i_run    (w_run),
    .i_clr    (w_accept),
    .i_len    (r_len),
    .i_gate   (r_len),
    .i_rdata  (k_rdata),
    .i_rdy    (K_rdy),
    .o_re     (k_re),
    .o_raddr  (k_raddr),
    .o_vld    (K_vld),
    .o_vector (w_k_vec),
    .o_acc    (w_k_acc)
  );

  // V index j may only be fetched once K index j has been delivered.
  kv_bcast_channel u_v_chan (
    .clk      (clk),
    .rst      (rst),
    .i_run    (w_run),
    .i_clr    (w_accept),
    .i_len    (r_len),
    .i_gate   (w_k_acc),
    .i_rdata  (v_rdata),
    .i_rdy    (V_rdy),
    .o_re     (v_re),
    .o_raddr  (v_raddr),
    .o_vld    (V_vld),
    .o_vector (w_v_vec),
    .o_acc    (w_v_acc)
  );

endmodule
